// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies the synchronized lock flag and releases sys_rst.
// Define PLL_LOCK_TIMEOUT_EN to re-reset the PLL when lock does not arrive in time.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_FILTER_CYCLES  = 1200,
    parameter int LOCK_TIMEOUT_CYCLES = 120000,
    parameter int HOLD_CYCLES         = 64,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // pll_locked is asynchronous to refclk; only lock_s is used downstream
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // Without the timeout feature the counter simply stays at zero here
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_FILTER;
                        cnt   <= '0;
                    end else if (TIMEOUT_EN && cnt == TIMEOUT_LAST) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        retry_cnt <= sat_inc(retry_cnt);
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_FILTER: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == FILTER_LAST) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (!lock_s) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        retry_cnt <= sat_inc(retry_cnt);
                    end else if (cnt == HOLD_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        retry_cnt <= sat_inc(retry_cnt);
                    end
                end
                default: begin
                    state   <= S_PLL_RST;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the system PLL (12 MHz refclk in; 80 MHz and 30 MHz out).
- Sits on the PLL control side, clocked by refclk because that clock exists before lock.
- Drives the PLL reset and consumes the asynchronous PLL `locked` flag.
- Produces a qualified system reset and ready flag for the 80/30 MHz domain reset synchronizers. Re-initialises the PLL on lock timeout or lock loss.

Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchronizer (min 2).
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per PLL reset pulse.
- LOCK_FILTER_CYCLES, 1200: consecutive cycles lock must stay high to qualify (100 us at 12 MHz).
- LOCK_TIMEOUT_CYCLES, 120000: maximum cycles waiting for lock before PLL re-reset (10 ms).
- HOLD_CYCLES, 64: extra cycles sys_rst is held after lock qualifies.
- CNT_W, 17: shared state counter width; must hold max(all cycle parameters) - 1.

Ports:
- refclk  in  1  supervisor clock, 12 MHz PLL reference.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked flag; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL rst input, active-high.
- sys_rst  out  1  system reset request, active-high; downstream re-synchronizes per domain.
- ready  out  1  high only while lock is qualified and held.
- retry_cnt  out  8  PLL re-reset events since rst, saturating.

Behaviour:
- Reset values (rst high at a refclk edge): state=S_PLL_RST, counter=0, sync chain=0, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0.
- rst has priority over every transition, including mid-operation.
- pll_locked passes through a SYNC_STAGES flop chain; the last stage is lock_s. No other logic samples pll_locked.
- All outputs are registered and reflect the current state, so there are no combinational paths from inputs to outputs.
- States and outputs:
  - S_PLL_RST: pll_rst=1, sys_rst=1, ready=0. Lasts exactly PLL_RST_CYCLES cycles, then goes to S_WAIT_LOCK with counter=0.
  - S_WAIT_LOCK: pll_rst=0, sys_rst=1. If lock_s=1, go to S_FILTER with counter=0. Else, if counter==LOCK_TIMEOUT_CYCLES-1, go to S_PLL_RST and increment retry_cnt. Else increment counter.
  - S_FILTER: sys_rst=1. If lock_s=0, go to S_WAIT_LOCK with counter=0; the timeout restarts and retry_cnt is unchanged. If lock_s=1 and counter==LOCK_FILTER_CYCLES-1, go to S_HOLD with counter=0. The state therefore occupies exactly LOCK_FILTER_CYCLES cycles.
  - S_HOLD: sys_rst=1, ready=0. If lock_s=0, go to S_PLL_RST and increment retry_cnt. After exactly HOLD_CYCLES cycles, go to S_RUN.
  - S_RUN: pll_rst=0, sys_rst=0, ready=1. If lock_s=0, go to S_PLL_RST and increment retry_cnt; sys_rst=1 and ready=0 from the next edge.
- Latency: the cycle lock_s first reads 1 in S_WAIT_LOCK is t. S_RUN (sys_rst=0) is entered at t+1+LOCK_FILTER_CYCLES+HOLD_CYCLES.
- retry_cnt saturates at 8'hFF and never wraps. The initial reset entry into S_PLL_RST does not count.
- The counter resets to 0 on every state change. It never exceeds the active state's limit.
- Illegal state encodings recover to S_PLL_RST on the next edge.

Optional Feature:
- Macro: PLL_LOCK_TIMEOUT_EN.
- Defined: S_WAIT_LOCK timeout behaves as above.
- Undefined: S_WAIT_LOCK waits indefinitely for lock_s and the counter holds 0. retry_cnt counts only lock losses from S_HOLD and S_RUN. LOCK_TIMEOUT_CYCLES is unused.

Test Plan:
- Bench parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_FILTER_CYCLES=8, LOCK_TIMEOUT_CYCLES=50, HOLD_CYCLES=6.
- Reset: rst high 3 cycles -> pll_rst=1, sys_rst=1, ready=0, retry_cnt=0. After release, pll_rst stays 1 for exactly 4 edges, then 0.
- Clean lock: pll_locked rises and stays high -> sys_rst falls and ready rises exactly 16 edges after the first edge sampling pll_locked=1 (2 sync + 8 filter + 6 hold). pll_rst stays 0.
- Lock glitch: pll_locked high 5 cycles, low 1 cycle, then high -> returns to S_WAIT_LOCK. sys_rst stays 1, retry_cnt=0, pll_rst stays 0. Qualification restarts from the second rise.
- Timeout (macro defined): pll_locked held 0 -> pll_rst rises after 50 cycles in S_WAIT_LOCK, holds 4 cycles, retry_cnt=1. Repeats periodically.
- Timeout (macro undefined): pll_locked held 0 for 1000 cycles -> pll_rst stays 0, retry_cnt=0.
- Lock loss in S_RUN: drop pll_locked -> sys_rst=1 and ready=0 within 3 edges, then pll_rst pulse of 4 cycles, retry_cnt+1. 300 forced losses -> retry_cnt=255.
- rst mid-S_HOLD: assert rst one cycle -> all outputs return to reset values on that edge and retry_cnt=0.
